spi_master_ctrl: RTL and testbench

- SPI initiator that drives the team's SPI slave + single-port RAM block from the host side.
- Serializes a 10-bit RAM command word onto MOSI. Bits [9:8] are the opcode: 00 write address, 01 write data, 10 read address, 11 read data. Bits [7:0] are the payload.
- For opcode 11 it also deserializes the 8-bit RAM read data returned on MISO.
- Used as the bench-side/system-side driver of the SPI slave; sits between host logic and the SPI pins.

---
 rtl/spi_master_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: shifts an (ADDR_SIZE+2)-bit RAM command out on MOSI and, for the
// read-data opcode, captures ADDR_SIZE bits from MISO. Starts arriving while busy are dropped.
module spi_master_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE+1:0] cmd,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 sclk,
  output logic                 ss_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(2 * CW + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  // Each phase is measured in half-period ticks; every phase ends on a falling tick.
  localparam logic [TW-1:0] SHIFT_LAST = TW'(2 * CW - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(1);
  localparam logic [TW-1:0] READ_LAST  = TW'(2 * ADDR_SIZE - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TURN,
    S_READ,
    S_GAP
  } state_t;

  state_t                 r_state,   w_state_nxt;
  logic [DW-1:0]          r_div;
  logic [TW-1:0]          r_tcnt,    w_tcnt_nxt;
  logic [CW-1:0]          r_shift,   w_shift_nxt;
  logic [ADDR_SIZE-1:0]   r_rx,      w_rx_nxt;
  logic                   r_rd_op,   w_rd_op_nxt;
  logic                   r_busy,    w_busy_nxt;
  logic                   r_done,    w_done_nxt;
  logic [ADDR_SIZE-1:0]   r_rd_data, w_rd_data_nxt;
  logic                   r_rd_vld,  w_rd_vld_nxt;
  logic                   r_sclk,    w_sclk_nxt;
  logic                   r_ss_n,    w_ss_n_nxt;
  logic                   r_mosi,    w_mosi_nxt;
  logic                   w_tick;

  assign w_tick = r_busy && (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (!r_busy || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_rd_op   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_sclk    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rx      <= w_rx_nxt;
      r_rd_op   <= w_rd_op_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rd_vld  <= w_rd_vld_nxt;
      r_sclk    <= w_sclk_nxt;
      r_ss_n    <= w_ss_n_nxt;
      r_mosi    <= w_mosi_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tcnt_nxt    = r_tcnt;
    w_shift_nxt   = r_shift;
    w_rx_nxt      = r_rx;
    w_rd_op_nxt   = r_rd_op;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_rd_data_nxt = r_rd_data;
    w_rd_vld_nxt  = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_ss_n_nxt    = r_ss_n;
    w_mosi_nxt    = r_mosi;

    if (w_tick) begin
      w_tcnt_nxt = r_tcnt + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tcnt_nxt = '0;
        if (start) begin
          w_shift_nxt = cmd;
          w_rd_op_nxt = (cmd[CW-1:CW-2] == 2'b11);
          w_busy_nxt  = 1'b1;
          w_ss_n_nxt  = 1'b0;
          w_mosi_nxt  = cmd[CW-1];
          w_state_nxt = S_SETUP;
        end
      end

      S_SETUP: begin
        if (w_tick) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          if (r_sclk) begin
            if (r_tcnt == SHIFT_LAST) begin
              w_mosi_nxt = 1'b0;
              w_tcnt_nxt = '0;
              if (r_rd_op) begin
                w_state_nxt = S_TURN;
              end else begin
                w_ss_n_nxt  = 1'b1;
                w_state_nxt = S_GAP;
              end
            end else begin
              w_shift_nxt = {r_shift[CW-2:0], 1'b0};
              w_mosi_nxt  = r_shift[CW-2];
            end
          end
        end
      end

      // One idle SCLK period lets the slave fetch from its RAM before it drives MISO.
      S_TURN: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          if (r_tcnt == TURN_LAST) begin
            w_tcnt_nxt  = '0;
            w_state_nxt = S_READ;
          end
        end
      end

      S_READ: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          if (!r_sclk) begin
            w_rx_nxt = {r_rx[ADDR_SIZE-2:0], miso};
          end else if (r_tcnt == READ_LAST) begin
            w_rd_data_nxt = r_rx;
            w_rd_vld_nxt  = 1'b1;
            w_ss_n_nxt    = 1'b1;
            w_tcnt_nxt    = '0;
            w_state_nxt   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (w_tick && (r_tcnt == GAP_LAST)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_vld;
  assign sclk     = r_sclk;
  assign ss_n     = r_ss_n;
  assign mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: bus monitor plus MISO slave model, frame expectations from the command word.
module tb_spi_master_ctrl;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] cmd = '0;
  logic       miso = 1'b0;
  logic       busy, done, rd_valid, sclk, ss_n, mosi;
  logic [7:0] rd_data;

  spi_master_ctrl #(.ADDR_SIZE(8), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  int cyc = 0, rise_total = 0, done_total = 0, rdv_total = 0, frame_falls = 0;
  int low_run = 0, high_run = 0, gap_run = 0;
  int last_low_len = 0, last_high_len = 0, last_gap_len = 0;
  int last_done_cyc = 0, last_rdv_cyc = 0, viol = 0;
  logic p_sclk = 1'b0, p_ss_n = 1'b1, p_busy = 1'b0;
  logic mosi_q[$];
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] exp_rd = 8'h00;

  // Bus monitor and mode-0 slave: MISO changes after falling edges, data starts after the turnaround.
  always @(negedge clk) begin
    cyc++;
    if (sclk && !p_sclk) begin
      rise_total++;
      mosi_q.push_back(mosi);
    end
    if (!sclk && p_sclk) begin
      frame_falls++;
      miso = (frame_falls >= 11 && frame_falls <= 18) ? slave_byte[18-frame_falls] : 1'b0;
    end
    if (ss_n) begin
      if (!p_ss_n) begin last_low_len = low_run; high_run = 0; end
      high_run++;
      frame_falls = 0;
      miso = 1'b0;
    end else begin
      if (p_ss_n) begin last_high_len = high_run; low_run = 0; end
      low_run++;
    end
    if (busy && ss_n) gap_run++;
    else begin
      if (!busy && p_busy) last_gap_len = gap_run;
      gap_run = 0;
    end
    if (done) begin done_total++; last_done_cyc = cyc; end
    if (rd_valid) begin rdv_total++; last_rdv_cyc = cyc; end
    if (ss_n && sclk) viol++;
    p_sclk = sclk;
    p_ss_n = ss_n;
    p_busy = busy;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] c, output bit to);
    int n;
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    cmd = c;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    to = !done;
  endtask

  task automatic get_bits(input int idx, output logic [9:0] v);
    v = 'x;
    for (int i = 0; i < 10; i++)
      if (idx + i < mosi_q.size()) v[9-i] = mosi_q[idx+i];
  endtask

  task automatic test_write_addr();
    bit to;
    int r0, q0, d0, v0;
    logic [9:0] c, got;
    c = 10'b00_11100110;
    slave_byte = 8'h00;
    r0 = rise_total; q0 = mosi_q.size(); d0 = done_total; v0 = rdv_total;
    send_frame(c, to);
    checks++; if (to !== 1'b0) $display("FAIL wr_timeout: done not seen"); else passes++;
    get_bits(q0, got);
    checks++; if (got !== c) $display("FAIL wr_bits: got %b expected %b", got, c); else passes++;
    checks++; if (rise_total - r0 !== 10) $display("FAIL wr_rises: got %0d expected 10", rise_total - r0); else passes++;
    checks++; if (last_low_len !== 21 * CLK_DIV) $display("FAIL wr_ss_low: got %0d expected %0d", last_low_len, 21 * CLK_DIV); else passes++;
    checks++; if (last_gap_len !== 2 * CLK_DIV) $display("FAIL wr_gap: got %0d expected %0d", last_gap_len, 2 * CLK_DIV); else passes++;
    repeat (4) step();
    checks++; if (done_total - d0 !== 1) $display("FAIL wr_done_cnt: got %0d expected 1", done_total - d0); else passes++;
    checks++; if (rdv_total - v0 !== 0) $display("FAIL wr_rdvalid: got %0d expected 0", rdv_total - v0); else passes++;
    checks++; if (viol !== 0) $display("FAIL ss_while_sclk_high: got %0d expected 0", viol); else passes++;
  endtask

  task automatic test_read_data();
    bit to;
    int r0, q0, v0;
    logic [9:0] c, got;
    c = 10'b11_00000000;
    slave_byte = 8'hA5;
    r0 = rise_total; q0 = mosi_q.size(); v0 = rdv_total;
    send_frame(c, to);
    exp_rd = 8'hA5;
    checks++; if (to !== 1'b0) $display("FAIL rd_timeout: done not seen"); else passes++;
    get_bits(q0, got);
    checks++; if (got !== c) $display("FAIL rd_cmd_bits: got %b expected %b", got, c); else passes++;
    checks++; if (mosi_q[q0+10] !== 1'b0) $display("FAIL rd_turn_mosi: got %b expected 0", mosi_q[q0+10]); else passes++;
    checks++; if (rise_total - r0 !== 19) $display("FAIL rd_rises: got %0d expected 19", rise_total - r0); else passes++;
    checks++; if (rd_data !== exp_rd) $display("FAIL rd_data: got %h expected %h", rd_data, exp_rd); else passes++;
    checks++; if (rdv_total - v0 !== 1) $display("FAIL rd_valid_cnt: got %0d expected 1", rdv_total - v0); else passes++;
    checks++; if (last_done_cyc - last_rdv_cyc !== 2 * CLK_DIV) $display("FAIL rd_valid_to_done: got %0d expected %0d", last_done_cyc - last_rdv_cyc, 2 * CLK_DIV); else passes++;
    checks++; if (last_low_len !== 39 * CLK_DIV) $display("FAIL rd_ss_low: got %0d expected %0d", last_low_len, 39 * CLK_DIV); else passes++;
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    exp_v = {1'b1, 5'b00000, 8'h00};
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if ({ss_n, sclk, mosi, busy, done, rd_valid, rd_data} !== exp_v)
      $display("FAIL reset_hold: got %b expected %b", {ss_n, sclk, mosi, busy, done, rd_valid, rd_data}, exp_v); else passes++;
    rst = 1'b0;
    step();
    checks++; if ({ss_n, sclk, mosi, busy, done, rd_valid, rd_data} !== exp_v)
      $display("FAIL reset_release: got %b expected %b", {ss_n, sclk, mosi, busy, done, rd_valid, rd_data}, exp_v); else passes++;
    exp_rd = 8'h00;
  endtask

  task automatic test_start_while_busy();
    int n, r0, q0, d0;
    logic [9:0] a, b, got;
    a = 10'b10_01011010;
    b = 10'b01_10100101;
    slave_byte = 8'h00;
    r0 = rise_total; q0 = mosi_q.size(); d0 = done_total;
    cmd = a; start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    cmd = b; start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    checks++; if (done !== 1'b1) $display("FAIL swb_timeout: done not seen"); else passes++;
    get_bits(q0, got);
    checks++; if (got !== a) $display("FAIL swb_bits: got %b expected %b", got, a); else passes++;
    checks++; if (rise_total - r0 !== 10) $display("FAIL swb_rises: got %0d expected 10", rise_total - r0); else passes++;
    repeat (6) step();
    checks++; if (done_total - d0 !== 1) $display("FAIL swb_done_cnt: got %0d expected 1", done_total - d0); else passes++;
    checks++; if ({busy, ss_n} !== 2'b01) $display("FAIL swb_idle_after: got %b expected 01", {busy, ss_n}); else passes++;
  endtask

  task automatic test_back_to_back();
    int n, q0, d0;
    logic [9:0] c1, c2, got;
    c1 = 10'b01_11111111;
    c2 = 10'b10_00111100;
    q0 = mosi_q.size(); d0 = done_total;
    cmd = c1; start = 1'b1; step();
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    checks++; if (done !== 1'b1) $display("FAIL b2b_timeout1: done not seen"); else passes++;
    cmd = c2;
    step();
    checks++; if ({busy, ss_n} !== 2'b10) $display("FAIL b2b_restart: got %b expected 10", {busy, ss_n}); else passes++;
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    checks++; if (done !== 1'b1) $display("FAIL b2b_timeout2: done not seen"); else passes++;
    get_bits(q0, got);
    checks++; if (got !== c1) $display("FAIL b2b_bits1: got %b expected %b", got, c1); else passes++;
    get_bits(q0 + 10, got);
    checks++; if (got !== c2) $display("FAIL b2b_bits2: got %b expected %b", got, c2); else passes++;
    checks++; if (last_high_len !== 2 * CLK_DIV + 1) $display("FAIL b2b_ss_high: got %0d expected %0d", last_high_len, 2 * CLK_DIV + 1); else passes++;
    checks++; if (done_total - d0 !== 2) $display("FAIL b2b_done_cnt: got %0d expected 2", done_total - d0); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int n, r0, q0, d0;
    logic [9:0] c, got;
    c = 10'b01_00110101;
    r0 = rise_total; d0 = done_total;
    cmd = c; start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (rise_total - r0 < 5 && n < 400) begin step(); n++; end
    checks++; if (rise_total - r0 !== 5) $display("FAIL rmf_fifth_rise: got %0d expected 5", rise_total - r0); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({ss_n, sclk, busy} !== 3'b100) $display("FAIL rmf_async: got %b expected 100", {ss_n, sclk, busy}); else passes++;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    exp_rd = 8'h00;
    checks++; if (done_total - d0 !== 0) $display("FAIL rmf_no_done: got %0d expected 0", done_total - d0); else passes++;
    c = 10'b00_01010101;
    q0 = mosi_q.size(); d0 = done_total;
    send_frame(c, to);
    checks++; if (to !== 1'b0) $display("FAIL rmf_timeout: done not seen"); else passes++;
    get_bits(q0, got);
    checks++; if (got !== c) $display("FAIL rmf_bits: got %b expected %b", got, c); else passes++;
    checks++; if (last_low_len !== 21 * CLK_DIV) $display("FAIL rmf_ss_low: got %0d expected %0d", last_low_len, 21 * CLK_DIV); else passes++;
    checks++; if (done_total - d0 !== 1) $display("FAIL rmf_done_cnt: got %0d expected 1", done_total - d0); else passes++;
  endtask

  task automatic test_random();
    bit to, is_rd;
    int r0, q0, v0, exp_rises, exp_low;
    logic [9:0] c, got;
    for (int k = 0; k < 12; k++) begin
      c = 10'($urandom_range(0, 1023));
      if (k % 3 == 0) c[9:8] = 2'b11;
      slave_byte = 8'($urandom_range(0, 255));
      is_rd = (c[9:8] == 2'b11);
      exp_rises = is_rd ? 19 : 10;
      exp_low = (is_rd ? 39 : 21) * CLK_DIV;
      if (is_rd) exp_rd = slave_byte;
      r0 = rise_total; q0 = mosi_q.size(); v0 = rdv_total;
      send_frame(c, to);
      checks++; if (to !== 1'b0) $display("FAIL rnd%0d_timeout: done not seen", k); else passes++;
      get_bits(q0, got);
      checks++; if (got !== c) $display("FAIL rnd%0d_bits: got %b expected %b", k, got, c); else passes++;
      checks++; if (rise_total - r0 !== exp_rises) $display("FAIL rnd%0d_rises: got %0d expected %0d", k, rise_total - r0, exp_rises); else passes++;
      checks++; if (last_low_len !== exp_low) $display("FAIL rnd%0d_ss_low: got %0d expected %0d", k, last_low_len, exp_low); else passes++;
      checks++; if (rd_data !== exp_rd) $display("FAIL rnd%0d_rd_data: got %h expected %h", k, rd_data, exp_rd); else passes++;
      checks++; if (rdv_total - v0 !== int'(is_rd)) $display("FAIL rnd%0d_rdvalid: got %0d expected %0d", k, rdv_total - v0, int'(is_rd)); else passes++;
    end
    checks++; if (viol !== 0) $display("FAIL rnd_ss_while_sclk_high: got %0d expected 0", viol); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    test_write_addr();
    test_read_data();
    test_reset();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
